framebuffer_writer: RTL and testbench

Write-side counterpart of the VGA scan-out reader. Accepts a raster-ordered RGB565 pixel stream from the console video generator, tracks x/y from framing flags, and writes each pixel into the 320x240 video RAM at y*H_RES+x. A small skid FIFO decouples the source from a RAM write port that can stall via an acknowledge.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/fb_fifo.sv | 52 +++++
 rtl/framebuffer_writer.sv | 172 +++++++++++++++++
 tb/tb_framebuffer_writer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer write path.
// The pixel record travels through the input FIFO as a packed struct.
package fb_pkg;

  localparam int FB_H_RES     = 320;
  localparam int FB_V_RES     = 240;
  localparam int FB_ADDR_W    = 17;
  localparam int FB_DATA_W    = 16;
  localparam int FB_LAST_ADDR = FB_H_RES * FB_V_RES - 1;

  // Coordinate counters only need to survive until the next sol/sof.
  localparam int FB_X_W = 10;
  localparam int FB_Y_W = 9;

  typedef struct packed {
    logic [FB_DATA_W-1:0] data;
    logic                 sof;
    logic                 sol;
  } pix_t;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/fb_fifo.sv
// Small synchronous FIFO with a registered occupancy count.
// The head entry is visible combinationally on rdata_o whenever empty_o is low.
module fb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Raster RGB565 stream to video RAM writer: tracks x/y from sof/sol, clips, writes at row_base+x.
// Define FB_SWAP_EN for double buffering (display_bank output, bank bit as mem_addr MSB).
module framebuffer_writer
  import fb_pkg::*;
#(
  parameter int H_RES      = FB_H_RES,
  parameter int V_RES      = FB_V_RES,
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_sol,
  input  logic              pix_sof,
`ifdef FB_SWAP_EN
  output logic [ADDR_W:0]   mem_addr,
`else
  output logic [ADDR_W-1:0] mem_addr,
`endif
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              frame_done,
  output logic              overflow,
`ifdef FB_SWAP_EN
  output logic              busy,
  output logic              display_bank
`else
  output logic              busy
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [FB_X_W-1:0] X_LIM     = FB_X_W'(H_RES);
  localparam logic [FB_Y_W-1:0] Y_LIM     = FB_Y_W'(V_RES);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(H_RES);

  pix_t                       push_pix, head_pix;
  logic                       fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                       push, pop, take;

  state_e                     state_q, state_d;
  logic [FB_X_W-1:0]          x_q, x_d;
  logic [FB_Y_W-1:0]          y_q, y_d;
  logic [ADDR_W-1:0]          row_q, row_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [DATA_W-1:0]          wdata_q, wdata_d;
  logic                       we_q, we_d;
  logic                       done_q, done_d;
  logic                       ovf_q, ovf_d;
  logic                       ready_en_q;

  assign push_pix.data = pix_data;
  assign push_pix.sof  = pix_sof;
  assign push_pix.sol  = pix_sol;

  // Ready stays low through reset and the first edge after release.
  assign pix_ready = ready_en_q && !fifo_full;
  assign push      = pix_valid && pix_ready;
  assign pop       = !fifo_empty && (!we_q || mem_ack);

  fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pix_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (push),
    .wdata_i (push_pix),
    .pop_i   (pop),
    .rdata_o (head_pix),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    row_d   = row_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    take    = 1'b0;

    if (we_q && mem_ack) we_d = 1'b0;

    if (pop) begin
      if (head_pix.sof) begin
        state_d = RUN;
        x_d     = '0;
        y_d     = '0;
        row_d   = '0;
        take    = 1'b1;
      end else if (state_q == RUN) begin
        take = 1'b1;
        if (head_pix.sol) begin
          x_d   = '0;
          y_d   = y_q + FB_Y_W'(1);
          row_d = row_q + ROW_STEP;
        end else begin
          x_d = x_q + FB_X_W'(1);
        end
      end

      // Out-of-range pixels still advance the counters but never reach the RAM.
      if (take && (x_d < X_LIM) && (y_d < Y_LIM)) begin
        we_d    = 1'b1;
        addr_d  = row_d + ADDR_W'(x_d);
        wdata_d = head_pix.data;
      end
    end

    done_d = we_q && mem_ack && (addr_q == LAST_ADDR);
    ovf_d  = ovf_q || (pix_valid && fifo_full);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= SYNC;
      x_q        <= '0;
      y_q        <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      ready_en_q <= 1'b1;
    end
  end

`ifdef FB_SWAP_EN
  logic bank_q;

  // The displayed bank flips on the same edge that raises frame_done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) bank_q <= 1'b0;
    else         bank_q <= bank_q ^ done_d;
  end

  assign display_bank = bank_q;
  assign mem_addr     = {~bank_q, addr_q};
`else
  assign mem_addr = addr_q;
`endif

  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;
  assign busy       = (fifo_count != '0) || we_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Randomized bench for framebuffer_writer against a raster-address reference model.
// Uses a reduced 24x10 raster so several whole frames fit in a short run.
module tb_framebuffer_writer;

  localparam int H     = 24;
  localparam int V     = 10;
  localparam int AW    = 17;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int NPIX  = H * V;
  localparam int LAST  = NPIX - 1;
`ifdef FB_SWAP_EN
  localparam int OAW = AW + 1;
`else
  localparam int OAW = AW;
`endif

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           pix_valid = 1'b0, pix_sol = 1'b0, pix_sof = 1'b0, mem_ack = 1'b0;
  logic [DW-1:0]  pix_data = '0;
  logic           pix_ready, mem_we, frame_done, overflow, busy;
  logic [OAW-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
`ifdef FB_SWAP_EN
  logic           display_bank;
`endif

  framebuffer_writer #(
    .H_RES      (H),
    .V_RES      (V),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_sol    (pix_sol),
    .pix_sof    (pix_sof),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .frame_done (frame_done),
    .overflow   (overflow),
`ifdef FB_SWAP_EN
    .busy       (busy),
    .display_bank (display_bank)
`else
    .busy       (busy)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t            exp_q[$];
  bit             synced, fd_exp, ovf_exp, pend, bank_exp;
  int             mx, my;
  logic [OAW-1:0] pend_addr;
  logic [DW-1:0]  pend_data;
  int             writes = 0, last_acked = -1, dut_fd_cnt = 0, stall_cnt = 0;
  int             ack_pct = 100, gap_pct = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Address as it should appear on the bus, including the write-bank MSB.
  function automatic logic [OAW-1:0] full_addr(input int a);
    logic [OAW-1:0] r;
    r = OAW'(a);
`ifdef FB_SWAP_EN
    r[AW] = !bank_exp;
`endif
    return r;
  endfunction

  function automatic bit rand_ack();
    return $urandom_range(99) < ack_pct;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    synced   = 1'b0;
    fd_exp   = 1'b0;
    ovf_exp  = 1'b0;
    pend     = 1'b0;
    bank_exp = 1'b0;
    mx       = 0;
    my       = 0;
  endtask

  // Reference: raster position from framing flags, linear address y*H+x.
  task automatic model_accept(input logic [DW-1:0] d, input logic sol, input logic sof);
    if (sof) begin
      synced = 1'b1;
      mx     = 0;
      my     = 0;
    end else if (!synced) begin
      return;
    end else if (sol) begin
      mx = 0;
      my = my + 1;
    end else begin
      mx = mx + 1;
    end
    if (mx < H && my < V) exp_q.push_back('{addr: my * H + mx, data: d});
  endtask

  // One clock: check registered outputs, drive the next inputs, score the handshakes.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic sol,
                      input logic sof, input logic ack, output bit acc);
    bit  fd_next;
    wr_t e;
    @(negedge clk);
    check("frame_done", frame_done, fd_exp);
    check("overflow", overflow, ovf_exp);
`ifdef FB_SWAP_EN
    check("display_bank", display_bank, bank_exp);
`endif
    if (frame_done) dut_fd_cnt++;
    if (pend) begin
      check("hold_we", mem_we, 1'b1);
      check("hold_addr", mem_addr, pend_addr);
      check("hold_data", mem_wdata, pend_data);
    end
    pix_valid = v;
    pix_data  = d;
    pix_sol   = sol;
    pix_sof   = sof;
    mem_ack   = ack;
    acc = v && pix_ready;
    if (v && !pix_ready) begin
      ovf_exp = 1'b1;
      stall_cnt++;
    end
    fd_next = 1'b0;
    if (mem_we && ack) begin
      check("wr_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, full_addr(e.addr));
        check("wr_data", mem_wdata, e.data);
        last_acked = e.addr;
        writes++;
        fd_next = (e.addr == LAST);
      end
    end
    pend      = mem_we && !ack;
    pend_addr = mem_addr;
    pend_data = mem_wdata;
    if (acc) model_accept(d, sol, sof);
    if (fd_next) bank_exp = !bank_exp;
    fd_exp = fd_next;
  endtask

  task automatic idle();
    bit acc;
    step(1'b0, '0, 1'b0, 1'b0, rand_ack(), acc);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic sol, input logic sof);
    bit acc = 1'b0;
    if ($urandom_range(99) < gap_pct) idle();
    for (int i = 0; i < 64 && !acc; i++) step(1'b1, d, sol, sof, rand_ack(), acc);
    if (!acc) check("send_timeout", acc, 1'b1);
  endtask

  task automatic send_range(input int k0, input int k1);
    for (int k = k0; k <= k1; k++) send(DW'($urandom), (k % H) == 0, k == 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      idle();
      if (!busy && exp_q.size() == 0) break;
    end
    check("drain_busy", busy, 1'b0);
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit            acc;
    int            w0, fd0, k, extra;
    logic [DW-1:0] d;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", pix_ready, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, full_addr(0));
    check("rst_wdata", mem_wdata, '0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    resetn = 1'b1;
    idle();
    check("ready_after_rst", pix_ready, 1'b1);

    // Pixels before the first sof must never be written.
    for (int i = 0; i < 6; i++) send(DW'($urandom), i == 2, 1'b0);
    drain();

    // First sof pixel: write visible two cycles after acceptance.
    w0  = writes;
    fd0 = dut_fd_cnt;
    step(1'b1, 16'hF800, 1'b1, 1'b1, 1'b1, acc);
    check("lat_accept", acc, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    check("lat_we_n1", mem_we, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    check("lat_we_n2", mem_we, 1'b1);
    check("lat_addr", mem_addr, full_addr(0));
    check("lat_data", mem_wdata, 16'hF800);

    // Rest of frame with ack always high: sustained one pixel per cycle.
    stall_cnt = 0;
    send_range(1, NPIX - 1);
    drain();
    check("tput_stalls", stall_cnt, 0);
    check("f1_writes", writes - w0, NPIX);
    check("f1_frame_done", dut_fd_cnt - fd0, 1);

    // RAM stall on pixel (3,2): FIFO fills after exactly DEPTH more accepts.
    fd0 = dut_fd_cnt;
    send_range(0, 2 * H + 2);
    drain();
    step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, acc);
    check("stall_accept", acc, 1'b1);
    k     = 2 * H + 4;
    extra = 0;
    d     = DW'($urandom);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, d, (k % H) == 0, 1'b0, 1'b0, acc);
      if (!acc) break;
      extra++;
      k++;
      d = DW'($urandom);
    end
    check("stall_accepts", extra, DEPTH);
    repeat (2) step(1'b1, d, (k % H) == 0, 1'b0, 1'b0, acc);
    check("stall_we", mem_we, 1'b1);
    check("stall_addr", mem_addr, full_addr(2 * H + 3));
    check("ovf_set", overflow, 1'b1);
    send(d, (k % H) == 0, 1'b0);
    send_range(k + 1, NPIX - 1);
    drain();
    check("f2_frame_done", dut_fd_cnt - fd0, 1);

    // Over-long first line: columns >= H are dropped, next sol lands at row 1.
    w0 = writes;
    for (int i = 0; i < H + 10; i++) send(DW'($urandom), i == 0, i == 0);
    drain();
    check("clip_writes", writes - w0, H);
    check("clip_last", last_acked, H - 1);
    send(DW'($urandom), 1'b1, 1'b0);
    drain();
    check("clip_next_sol", last_acked, H);

    // Random ack and gaps; the second frame is truncated by a new sof.
    ack_pct = 60;
    gap_pct = 30;
    fd0     = dut_fd_cnt;
    for (int f = 0; f < 4; f++) send_range(0, (f == 1) ? (NPIX / 2) : (NPIX - 1));
    drain();
    check("rand_frames", dut_fd_cnt - fd0, 3);
    check("ovf_sticky", overflow, 1'b1);

    // Asynchronous reset while a write is outstanding.
    ack_pct = 100;
    gap_pct = 0;
    step(1'b1, DW'($urandom), 1'b1, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    check("mw_we", mem_we, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("mw_rst_we", mem_we, 1'b0);
    check("mw_rst_ovf", overflow, 1'b0);
    check("mw_rst_ready", pix_ready, 1'b0);
    check("mw_rst_busy", busy, 1'b0);
    model_reset();
    pix_valid = 1'b0;
    mem_ack   = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) idle();
    check("post_rst_ready", pix_ready, 1'b1);
    check("post_rst_ovf", overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
